// File: rtl/int_sqrt_pkg.sv
// Shared definitions for the sequential integer square-root unit.
// Holds operand/root widths, the default multiplier depth and the FSM state type.
package int_sqrt_pkg;
  localparam int VALUE_W         = 64;
  localparam int ROOT_W          = 32;
  localparam int IDX_W           = 5;
  localparam int MULT_STAGES_DEF = 4;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_TRY,
    ST_WAIT,
    ST_DECIDE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sqrt_mult.sv
// Pipelined unsigned 32x32 -> 64 multiplier with a fixed latency of MULT_STAGES.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high, clears every pipeline register
//   a, b    - 32-bit unsigned operands
//   product - a*b, available MULT_STAGES edges after the operands are presented
module sqrt_mult
  import int_sqrt_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ROOT_W-1:0]  a,
  input  logic [ROOT_W-1:0]  b,
  output logic [VALUE_W-1:0] product
);

  logic [MULT_STAGES-1:0][VALUE_W-1:0] pipe;

  // Product is formed in the first stage; the remaining stages only delay it,
  // leaving retiming free to spread the multiply across them.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= VALUE_W'(a) * VALUE_W'(b);
      for (int i = 1; i < MULT_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign product = pipe[MULT_STAGES-1];

endmodule

// File: rtl/int_sqrt.sv
// Sequential unsigned integer square root: result = floor(sqrt(value)).
// Restoring bit-by-bit search from bit 31 down to bit 0; each candidate root is
// squared in the pipelined multiplier and kept if its square fits the operand.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high; aborts any computation and starts a new one
//   value  - 64-bit radicand, captured on the first edge with reset low
//   result - 32-bit root, meaningful while done=1
//   done   - high once result is final, held until the next reset
// Latency from the first edge with reset low to done: 1 + 32*(MULT_STAGES+2).
module int_sqrt
  import int_sqrt_pkg::*;
#(
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  output logic [ROOT_W-1:0]  result,
  output logic               done
);

  localparam int WCNT_W = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [VALUE_W-1:0]  operand;
  logic [ROOT_W-1:0]   trial;
  logic [WCNT_W-1:0]   wcnt;
  logic [VALUE_W-1:0]  product;

  // trial is registered, so the multiplier samples it on the first WAIT edge
  // and the product is ready exactly when DECIDE executes.
  sqrt_mult #(.MULT_STAGES(MULT_STAGES)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .a       (trial),
    .b       (trial),
    .product (product)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_LOAD;
      result  <= '0;
      done    <= 1'b0;
      idx     <= IDX_W'(ROOT_W-1);
      operand <= '0;
      trial   <= '0;
      wcnt    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          operand <= value;
          result  <= '0;
          idx     <= IDX_W'(ROOT_W-1);
          state   <= ST_TRY;
        end
        ST_TRY: begin
          trial <= result | (ROOT_W'(1) << idx);
          wcnt  <= WCNT_W'(MULT_STAGES-1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // MULT_STAGES edges spent here: wcnt counts MULT_STAGES-1 down to 0
          if (wcnt == '0) state <= ST_DECIDE;
          else            wcnt  <= wcnt - 1'b1;
        end
        ST_DECIDE: begin
          if (product <= operand) result <= trial;
          if (idx == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            idx   <= idx - 1'b1;
            state <= ST_TRY;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sqrt.sv
// Self-checking bench for int_sqrt: a Newton-iteration reference root is
// computed when the operand is captured, and a monitor compares done timing
// and the root against it every cycle.
module tb_int_sqrt;
  localparam int MS  = 4;
  localparam int LAT = 1 + 32 * (MS + 2);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] value = '0;
  logic [31:0] result;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // model state: edges since the last reset edge, captured operand and its root
  int          cyc     = 0;
  logic [63:0] model_v = '0;
  logic [31:0] model_r = '0;

  int_sqrt #(.MULT_STAGES(MS)) dut (
    .clock  (clock),
    .reset  (reset),
    .value  (value),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Integer Newton iteration on 128 bits; converges to floor(sqrt(v)).
  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [127:0] x, y, vv;
    if (v < 64'd2) return v[31:0];
    vv = {64'd0, v};
    x  = vv;
    y  = (x + 128'd1) / 128'd2;
    while (y < x) begin
      x = y;
      y = (x + vv / x) / 128'd2;
    end
    return x[31:0];
  endfunction

  function automatic logic in_bounds(input logic [31:0] r, input logic [63:0] v);
    logic [127:0] rr, vv;
    rr = {96'd0, r};
    vv = {64'd0, v};
    return (rr * rr <= vv) && ((rr + 128'd1) * (rr + 128'd1) > vv);
  endfunction

  // Monitor: samples inputs at the edge, outputs 1 time unit later.
  always @(posedge clock) begin : mon
    logic        rs;
    logic [63:0] vs;
    rs = reset;
    vs = value;
    #1;
    if (rs) cyc = 0;
    else if (cyc < 100000) cyc++;
    if (cyc == 1) begin
      model_v = vs;
      model_r = isqrt(vs);
    end
    if (cyc == 0) begin
      chk("reset_done", {127'd0, done}, 128'd0);
      chk("reset_result", {96'd0, result}, 128'd0);
    end else begin
      chk("done_timing", {127'd0, done}, (cyc >= LAT) ? 128'd1 : 128'd0);
      if (cyc >= LAT) begin
        chk("root", {96'd0, result}, {96'd0, model_r});
        chk("root_bounds", {127'd0, in_bounds(result, model_v)}, 128'd1);
      end
    end
  end

  // Reset, present v, scramble value after LOAD, wait for done, hold 10 cycles.
  task automatic run(input logic [63:0] v, output logic [31:0] r);
    int n;
    @(negedge clock); reset = 1'b1; value = v;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); value = {$urandom, $urandom};
    n = 0;
    while (!done && n < LAT + 50) begin
      @(negedge clock);
      n++;
    end
    if (!done) chk("timeout", 128'd0, 128'd1);
    else       chk("latency", 128'(cyc), 128'(LAT));
    repeat (10) @(negedge clock);
    r = result;
  endtask

  initial begin
    logic [31:0] r, t;
    logic [63:0] v;

    // pin the reference model itself
    chk("model_24",   {96'd0, isqrt(64'd24)},    128'd4);
    chk("model_1001", {96'd0, isqrt(64'd1001)},  128'd31);
    chk("model_65536",{96'd0, isqrt(64'd65536)}, 128'd256);
    chk("model_15",   {96'd0, isqrt(64'd15)},    128'd3);
    chk("model_max",  {96'd0, isqrt(64'hFFFF_FFFF_FFFF_FFFF)}, 128'hFFFF_FFFF);

    repeat (2) @(negedge clock);

    run(64'd24, r);    chk("dir_24",    {96'd0, r}, 128'd4);
    run(64'd1001, r);  chk("dir_1001",  {96'd0, r}, 128'd31);
    run(64'd65536, r); chk("dir_65536", {96'd0, r}, 128'd256);
    run(64'd0, r);     chk("dir_0",     {96'd0, r}, 128'd0);
    run(64'd1, r);     chk("dir_1",     {96'd0, r}, 128'd1);
    run(64'hFFFF_FFFF_FFFF_FFFF, r); chk("dir_max", {96'd0, r}, 128'hFFFF_FFFF);
    run(64'hFFFF_FFFE_0000_0000, r); chk("dir_sq_m1", {96'd0, r}, 128'hFFFF_FFFE);

    // abort mid-computation, then restart with a new operand
    @(negedge clock); reset = 1'b1; value = 64'd1001;
    @(negedge clock); reset = 1'b0;
    repeat (50) @(negedge clock);
    run(64'd24, r);    chk("abort_24",  {96'd0, r}, 128'd4);

    for (int i = 0; i < 12; i++) begin
      t = $urandom;
      case (i % 3)
        0:       v = {$urandom, $urandom};
        1:       v = {{32{t[31]}}, t};
        default: v = {32'd0, t} * {32'd0, t} - 64'(i & 1);
      endcase
      run(v, r);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
